alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters: port 0 (execute stage)
//  and port 1 (branch-compare/debug unit). Each request carries operands and command;
//  the response returns alu_out and flag. Sits between the requesters and the ALU instance.
//  Arbitration is round-robin (or fixed priority) with valid/ready handshakes.
// PARAMETERS
//  DATA_W   32  operand/result width
//  CMD_W    4   ex_cmd width
//  OP_W     2   ALUOp width
//  RR       1   1 = round-robin; 0 = fixed priority, port 0 wins
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  rq0_valid    in   1       port-0 request valid; held stable until rq0_ready
//  rq0_ready    out  1       port-0 request accepted this cycle
//  rq0_a/rq0_b  in   DATA_W  operands (input1/input2)
//  rq0_cmd      in   CMD_W   ex_cmd
//  rq0_aluop    in   OP_W    ALUOp
//  rq0_branch   in   1       branchD
//  rq1_*        --   --      identical set for port 1
//  rs0_valid    out  1       result for port 0 available
//  rs0_ready    in   1       port 0 takes result
//  rs1_valid    out  1       result for port 1 available
//  rs1_ready    in   1       port 1 takes result
//  rs_data      out  DATA_W  registered alu_out (shared by both ports)
//  rs_flag      out  1       registered flag
//  alu_in1/alu_in2 out DATA_W  registered ALU operands
//  alu_cmd      out  CMD_W   ALU ex_cmd
//  alu_aluop    out  OP_W    ALU ALUOp
//  alu_branch   out  1       ALU branchD
//  alu_out      in   DATA_W  ALU result (combinational from alu_* outputs)
//  alu_flag     in   1       ALU flag
//  busy         out  1       state != IDLE
//  owner        out  1       port currently owning the ALU
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=1 so port 0 wins the first tie.
//  FSM IDLE -> EXEC -> RESP -> IDLE. Only one operation is in flight.
//  IDLE:
//   - Winner = sole valid port; on a tie, RR ? !last_grant : 0.
//   - rqX_ready = 1 only for the winner, only in IDLE (combinational).
//   - On handshake: latch operands/cmd into alu_* registers; owner := winner; -> EXEC.
//  EXEC (1 cycle): capture alu_out/alu_flag into rs_data/rs_flag; -> RESP.
//  RESP:
//   - rsX_valid = 1 for owner only; rs_data/rs_flag stay stable until rsX_ready.
//   - On rsX_ready: last_grant := owner; -> IDLE.
//   - rsX_ready may already be high when rsX_valid rises; the transfer completes that cycle.
//  Timing:
//   - Latency from request handshake to rs_valid rise is 2 cycles.
//   - Best-case throughput is 1 operation per 3 cycles.
//   - Requests arriving in EXEC/RESP wait with ready=0.
//  Ready/valid rules:
//   - rsX_ready from the non-owner is ignored.
//   - A request dropped before its handshake is protocol violation; the arbiter re-samples it each IDLE cycle.
//  Held values:
//   - alu_* registers hold their last values while IDLE (no toggling).
//   - rs_data/rs_flag hold until the next EXEC.
//  Reset mid-operation: the in-flight op is discarded and no response is issued.
//  All arithmetic is in the ALU; this block does no width conversion.
// STRUCTURE
//  Package alu_arb_pkg holds:
//   - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
//   - DATA_W/CMD_W/OP_W defaults
//  Sub-module rr_arb2: 2-input grant logic (req[1:0], last_grant, RR -> gnt[1:0]).
//  The ALU stays external and is instanced beside this block at the top level.
// TESTING
//  1. rq0: a=88, b=88, cmd=4'b1111, aluop=2, branch=0
//     -> rq0_ready in the handshake cycle; rs0_valid 2 cycles later with rs_flag=1,
//        rs_data equal to a direct ALU instance driven with the same inputs.
//  2. rq0 and rq1 both valid from reset, RR=1, responses accepted at once
//     -> grant order 0,1,0,1 over 4 ops; owner toggles; each rs_valid goes only to its owner.
//  3. Same as 2 with RR=0 -> port 0 serviced all 4 times; port 1 waits with rq1_ready=0.
//  4. rs1_ready held low 5 cycles in RESP while rq0 is valid
//     -> rs_data/rs_flag stable; rq0_ready=0 until rs1_ready=1, then rq0 is granted next IDLE.
//  5. reset asserted in EXEC -> next edge: busy=0, rs0/rs1_valid=0, alu_*=0, no response.
//  6. Single request on port 1 with port 0 idle -> port 1 granted immediately despite tie-break state.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CMD_W_DEF  = 4;
  localparam int OP_W_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input grant logic: a sole requester always wins; a tie goes to port 0
// under fixed priority, or to the port that did not win last under round-robin.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the previous winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (RR && !last_grant) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. One operation
// is in flight at a time: IDLE (arbitrate) -> EXEC (ALU evaluates) -> RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CMD_W  = CMD_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic [DATA_W-1:0] rq0_a,
  input  logic [DATA_W-1:0] rq0_b,
  input  logic [CMD_W-1:0]  rq0_cmd,
  input  logic [OP_W-1:0]   rq0_aluop,
  input  logic              rq0_branch,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic [DATA_W-1:0] rq1_a,
  input  logic [DATA_W-1:0] rq1_b,
  input  logic [CMD_W-1:0]  rq1_cmd,
  input  logic [OP_W-1:0]   rq1_aluop,
  input  logic              rq1_branch,
  output logic              rs0_valid,
  input  logic              rs0_ready,
  output logic              rs1_valid,
  input  logic              rs1_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic              rs_flag,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CMD_W-1:0]  alu_cmd,
  output logic [OP_W-1:0]   alu_aluop,
  output logic              alu_branch,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag,
  output logic              busy,
  output logic              owner
);

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic [1:0] gnt;
  logic       req_take;
  logic       resp_take;

  rr_arb2 #(
    .RR(RR)
  ) u_arb (
    .req       ({rq1_valid, rq0_valid}),
    .last_grant(last_grant_q),
    .gnt       (gnt)
  );

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus handshake outputs, which only the current state gates
  always_comb begin
    state_d   = state_q;
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    rs0_valid = 1'b0;
    rs1_valid = 1'b0;
    busy      = 1'b1;
    req_take  = 1'b0;
    resp_take = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        rq0_ready = gnt[0];
        rq1_ready = gnt[1];
        req_take  = |gnt;
        if (req_take) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rs0_valid = ~owner;
        rs1_valid = owner;
        // The non-owner's ready never completes a transfer
        resp_take = owner ? rs1_ready : rs0_ready;
        if (resp_take) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch on grant (held while idle), result capture in EXEC, tie-break update on response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_cmd      <= '0;
      alu_aluop    <= '0;
      alu_branch   <= 1'b0;
      owner        <= 1'b0;
      rs_data      <= '0;
      rs_flag      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (req_take) begin
        owner      <= gnt[1];
        alu_in1    <= gnt[1] ? rq1_a      : rq0_a;
        alu_in2    <= gnt[1] ? rq1_b      : rq0_b;
        alu_cmd    <= gnt[1] ? rq1_cmd    : rq0_cmd;
        alu_aluop  <= gnt[1] ? rq1_aluop  : rq0_aluop;
        alu_branch <= gnt[1] ? rq1_branch : rq0_branch;
      end
      if (state_q == EXEC) begin
        rs_data <= alu_out;
        rs_flag <= alu_flag;
      end
      if (resp_take) last_grant_q <= owner;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share the request-side stimulus; each drives its own ALU model.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic [3:0]  rq0_cmd, rq1_cmd;
  logic [1:0]  rq0_aluop, rq1_aluop;
  logic        rq0_branch, rq1_branch;
  logic        rs0_ready, rs1_ready;

  logic        rr_rq0_ready, rr_rq1_ready, rr_rs0_valid, rr_rs1_valid;
  logic [31:0] rr_rs_data, rr_alu_in1, rr_alu_in2, rr_alu_out;
  logic        rr_rs_flag, rr_alu_branch, rr_alu_flag, rr_busy, rr_owner;
  logic [3:0]  rr_alu_cmd;
  logic [1:0]  rr_alu_aluop;

  logic        fp_rq0_ready, fp_rq1_ready, fp_rs0_valid, fp_rs1_valid;
  logic [31:0] fp_rs_data, fp_alu_in1, fp_alu_in2, fp_alu_out;
  logic        fp_rs_flag, fp_alu_branch, fp_alu_flag, fp_busy, fp_owner;
  logic [3:0]  fp_alu_cmd;
  logic [1:0]  fp_alu_aluop;

  int tests = 0;
  int fails = 0;

  // Stand-in ALU: result selected by cmd, offset by ALUOp; flag is
  // equality, or inequality when branchD is set.
  function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] cmd, input logic [1:0] op);
    logic [31:0] r;
    case (cmd)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd15:   r = a - b;
      default: r = a ^ b;
    endcase
    return r + {30'd0, op};
  endfunction

  function automatic logic alu_flg(input logic [31:0] a, input logic [31:0] b, input logic br);
    return br ? (a != b) : (a == b);
  endfunction

  assign rr_alu_out  = alu_res(rr_alu_in1, rr_alu_in2, rr_alu_cmd, rr_alu_aluop);
  assign rr_alu_flag = alu_flg(rr_alu_in1, rr_alu_in2, rr_alu_branch);
  assign fp_alu_out  = alu_res(fp_alu_in1, fp_alu_in2, fp_alu_cmd, fp_alu_aluop);
  assign fp_alu_flag = alu_flg(fp_alu_in1, fp_alu_in2, fp_alu_branch);

  alu_arbiter #(.DATA_W(32), .CMD_W(4), .OP_W(2), .RR(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rr_rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq0_cmd(rq0_cmd), .rq0_aluop(rq0_aluop), .rq0_branch(rq0_branch),
    .rq1_valid(rq1_valid), .rq1_ready(rr_rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rq1_cmd(rq1_cmd), .rq1_aluop(rq1_aluop), .rq1_branch(rq1_branch),
    .rs0_valid(rr_rs0_valid), .rs0_ready(rs0_ready),
    .rs1_valid(rr_rs1_valid), .rs1_ready(rs1_ready),
    .rs_data(rr_rs_data), .rs_flag(rr_rs_flag),
    .alu_in1(rr_alu_in1), .alu_in2(rr_alu_in2), .alu_cmd(rr_alu_cmd),
    .alu_aluop(rr_alu_aluop), .alu_branch(rr_alu_branch),
    .alu_out(rr_alu_out), .alu_flag(rr_alu_flag),
    .busy(rr_busy), .owner(rr_owner)
  );

  alu_arbiter #(.DATA_W(32), .CMD_W(4), .OP_W(2), .RR(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(fp_rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq0_cmd(rq0_cmd), .rq0_aluop(rq0_aluop), .rq0_branch(rq0_branch),
    .rq1_valid(rq1_valid), .rq1_ready(fp_rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rq1_cmd(rq1_cmd), .rq1_aluop(rq1_aluop), .rq1_branch(rq1_branch),
    .rs0_valid(fp_rs0_valid), .rs0_ready(rs0_ready),
    .rs1_valid(fp_rs1_valid), .rs1_ready(rs1_ready),
    .rs_data(fp_rs_data), .rs_flag(fp_rs_flag),
    .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2), .alu_cmd(fp_alu_cmd),
    .alu_aluop(fp_alu_aluop), .alu_branch(fp_alu_branch),
    .alu_out(fp_alu_out), .alu_flag(fp_alu_flag),
    .busy(fp_busy), .owner(fp_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("check %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e;
    reset = 1'b1;
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rq0_a = '0; rq0_b = '0; rq0_cmd = '0; rq0_aluop = '0; rq0_branch = 1'b0;
    rq1_a = '0; rq1_b = '0; rq1_cmd = '0; rq1_aluop = '0; rq1_branch = 1'b0;
    rs0_ready = 1'b0; rs1_ready = 1'b0;
    tick(); tick();

    // Reset state
    check1("rst_busy", rr_busy, 1'b0);
    check1("rst_owner", rr_owner, 1'b0);
    check1("rst_rs0_valid", rr_rs0_valid, 1'b0);
    check1("rst_rs1_valid", rr_rs1_valid, 1'b0);
    check("rst_alu_in1", rr_alu_in1, 32'd0);
    check("rst_rs_data", rr_rs_data, 32'd0);
    check1("rst_rs_flag", rr_rs_flag, 1'b0);
    reset = 1'b0;

    // Single op on port 0: handshake, 2-cycle latency, hold until taken
    rq0_a = 32'd88; rq0_b = 32'd88; rq0_cmd = 4'd15; rq0_aluop = 2'd2; rq0_branch = 1'b0;
    rq0_valid = 1'b1;
    #1;
    check1("t1_rq0_ready", rr_rq0_ready, 1'b1);
    check1("t1_rq1_ready", rr_rq1_ready, 1'b0);
    tick();
    rq0_valid = 1'b0;
    #1;
    check1("t1_busy", rr_busy, 1'b1);
    check1("t1_owner", rr_owner, 1'b0);
    check("t1_alu_in1", rr_alu_in1, 32'd88);
    check("t1_alu_in2", rr_alu_in2, 32'd88);
    check("t1_alu_cmd", {28'd0, rr_alu_cmd}, 32'd15);
    check("t1_alu_aluop", {30'd0, rr_alu_aluop}, 32'd2);
    check1("t1_alu_branch", rr_alu_branch, 1'b0);
    check1("t1_rs0_valid_exec", rr_rs0_valid, 1'b0);
    check1("t1_rq0_ready_exec", rr_rq0_ready, 1'b0);
    tick();
    check1("t1_rs0_valid", rr_rs0_valid, 1'b1);
    check1("t1_rs1_valid", rr_rs1_valid, 1'b0);
    check("t1_rs_data", rr_rs_data, 32'd2);
    check1("t1_rs_flag", rr_rs_flag, 1'b1);
    tick();
    check1("t1_rs0_valid_hold", rr_rs0_valid, 1'b1);
    check("t1_rs_data_hold", rr_rs_data, 32'd2);
    rs0_ready = 1'b1;
    tick();
    rs0_ready = 1'b0;
    check1("t1_busy_done", rr_busy, 1'b0);
    check1("t1_rs0_valid_done", rr_rs0_valid, 1'b0);
    check("t1_alu_in1_held", rr_alu_in1, 32'd88);
    check("t1_rs_data_held", rr_rs_data, 32'd2);

    // Both ports valid from reset: round-robin alternates, fixed priority starves port 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rq0_a = 32'd10; rq0_b = 32'd3; rq0_cmd = 4'd0; rq0_aluop = 2'd0; rq0_branch = 1'b0;
    rq1_a = 32'd10; rq1_b = 32'd3; rq1_cmd = 4'd1; rq1_aluop = 2'd1; rq1_branch = 1'b1;
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2) == 1;
      #1;
      check1("t2_rq0_ready", rr_rq0_ready, !e);
      check1("t2_rq1_ready", rr_rq1_ready, e);
      check1("t3_rq0_ready", fp_rq0_ready, 1'b1);
      check1("t3_rq1_ready", fp_rq1_ready, 1'b0);
      tick();
      check1("t2_owner", rr_owner, e);
      check1("t3_owner", fp_owner, 1'b0);
      check1("t3_rq1_wait", fp_rq1_ready, 1'b0);
      tick();
      check1("t2_rs0_valid", rr_rs0_valid, !e);
      check1("t2_rs1_valid", rr_rs1_valid, e);
      check("t2_rs_data", rr_rs_data, e ? 32'd8 : 32'd13);
      check1("t2_rs_flag", rr_rs_flag, e);
      check1("t3_rs0_valid", fp_rs0_valid, 1'b1);
      check1("t3_rs1_valid", fp_rs1_valid, 1'b0);
      check("t3_rs_data", fp_rs_data, 32'd13);
      tick();
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rs0_ready = 1'b0; rs1_ready = 1'b0;

    // Lone port-1 request wins despite the port-0 tie-break after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rq1_a = 32'd100; rq1_b = 32'd37; rq1_cmd = 4'd2; rq1_aluop = 2'd0; rq1_branch = 1'b1;
    rq1_valid = 1'b1;
    #1;
    check1("t6_rq1_ready", rr_rq1_ready, 1'b1);
    check1("t6_rq0_ready", rr_rq0_ready, 1'b0);
    tick();
    rq1_valid = 1'b0;

    // Port 1 stalls its response while port 0 waits; port-0 ready is ignored meanwhile
    rq0_a = 32'd5; rq0_b = 32'd6; rq0_cmd = 4'd3; rq0_aluop = 2'd3; rq0_branch = 1'b0;
    rq0_valid = 1'b1;
    rs0_ready = 1'b1; rs1_ready = 1'b0;
    #1;
    check1("t6_owner", rr_owner, 1'b1);
    check1("t6_alu_branch", rr_alu_branch, 1'b1);
    check1("t4_rq0_ready_exec", rr_rq0_ready, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check1("t4_rs1_valid", rr_rs1_valid, 1'b1);
      check1("t4_rs0_valid", rr_rs0_valid, 1'b0);
      check("t4_rs_data", rr_rs_data, 32'd36);
      check1("t4_rs_flag", rr_rs_flag, 1'b1);
      check1("t4_rq0_ready", rr_rq0_ready, 1'b0);
      tick();
    end
    rs1_ready = 1'b1;
    #1;
    check1("t4_rs1_valid_last", rr_rs1_valid, 1'b1);
    tick();
    rs1_ready = 1'b0;
    #1;
    check1("t4_busy_idle", rr_busy, 1'b0);
    check1("t4_rq0_granted", rr_rq0_ready, 1'b1);
    tick();
    rq0_valid = 1'b0;
    check1("t4_owner0", rr_owner, 1'b0);
    check("t4_alu_in1", rr_alu_in1, 32'd5);
    tick();
    check1("t4_rs0_valid", rr_rs0_valid, 1'b1);
    check("t4_rs_data0", rr_rs_data, 32'd10);
    check1("t4_rs_flag0", rr_rs_flag, 1'b0);
    tick();
    check1("t4_busy_done", rr_busy, 1'b0);
    rs0_ready = 1'b0;

    // Reset while in EXEC discards the operation
    rq0_a = 32'd7; rq0_b = 32'd2; rq0_cmd = 4'd0; rq0_aluop = 2'd1; rq0_branch = 1'b0;
    rq0_valid = 1'b1;
    #1;
    tick();
    rq0_valid = 1'b0;
    check1("t5_busy_exec", rr_busy, 1'b1);
    check("t5_alu_in1_exec", rr_alu_in1, 32'd7);
    reset = 1'b1;
    #1;
    check1("t5_busy", rr_busy, 1'b0);
    check1("t5_rs0_valid", rr_rs0_valid, 1'b0);
    check1("t5_rs1_valid", rr_rs1_valid, 1'b0);
    check("t5_alu_in1", rr_alu_in1, 32'd0);
    check("t5_alu_in2", rr_alu_in2, 32'd0);
    check("t5_alu_cmd", {28'd0, rr_alu_cmd}, 32'd0);
    check("t5_alu_aluop", {30'd0, rr_alu_aluop}, 32'd0);
    check1("t5_owner", rr_owner, 1'b0);
    check("t5_rs_data", rr_rs_data, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check1("t5_no_resp_a", rr_rs0_valid, 1'b0);
    tick();
    check1("t5_no_resp_b", rr_rs0_valid, 1'b0);
    check1("t5_idle", rr_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
